score_readout: RTL and testbench
================================

// Module: score_readout
// PURPOSE
// Read-side companion to the game controller: once a game finishes, walks the stored
// reaction-time scores in the register file and computes their average and best (minimum).
// It then lets the player page through the results on the 13-bit score display with the hit button.
// It sits between the register file's P read port and the display.
// It never writes the register file.
// PARAMETERS
// NUM_SCORES  3   scores held at register addresses 1..NUM_SCORES; address 0 is the round counter
// ADDR_W      3   register file address width; must satisfy 2**ADDR_W > NUM_SCORES
// SUM_W       15  accumulator width = 13 + clog2(NUM_SCORES+1); must hold NUM_SCORES*8191
// PORTS
// Clock          in   1       system clock; all state updates on its rising edge
// Reset          in   1       synchronous, active-high reset
// start          in   1       one-cycle pulse from the game controller: game over, begin readout
// buttonNext     in   1       one-cycle pulse (already debounced/edge-detected): advance display view
// regAddrP       out  ADDR_W  register file read address, port P
// registerDataP  in   13      register file read data; combinational, valid in the same cycle as regAddrP
// DisplayScore   out  13      value to show on the display
// viewSel        out  2       0=average, 1=best, 2=individual score (index given by scoreIndex)
// scoreIndex     out  ADDR_W  register address of the score shown (best or individual view); 0 otherwise
// busy           out  1       high in READ and DIVIDE
// done           out  1       high while in SHOW
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; accumulator, best, bestIdx, quotient and view counter cleared.
//   Reset overrides every other input in the same cycle and aborts any state immediately.
// - IDLE: regAddrP=0, outputs 0. On start go to READ with index i=1, sum=0, best=13'h1FFF, bestIdx=1.
// - READ (NUM_SCORES cycles): regAddrP=i; each edge:
//   - sum += registerDataP, zero-extended to SUM_W;
//   - if registerDataP < best (strict), then best<=data and bestIdx<=i, so a tie keeps the lower index;
//   - i += 1. After i=NUM_SCORES has been sampled, go to DIVIDE.
// - DIVIDE (exactly SUM_W cycles): restoring shift-subtract of sum by NUM_SCORES, one quotient bit per cycle.
//   - avg = floor(sum/NUM_SCORES), truncated to 13 bits; the value is guaranteed to be <= 8191.
//   - Then go to SHOW with view=0.
// - Latency: the start-sampling edge is edge 0; done rises after edge NUM_SCORES+SUM_W (18 with defaults).
//   busy is high from edge 0 through that edge.
// - SHOW views, cycled by buttonNext:
//   - view 0: DisplayScore=avg, viewSel=0, scoreIndex=0.
//   - view 1: DisplayScore=best, viewSel=1, scoreIndex=bestIdx.
//   - views 2..NUM_SCORES+1: regAddrP=view-1, DisplayScore=registerDataP, viewSel=2, scoreIndex=view-1.
//   - buttonNext on the last view wraps to view 0.
// - SHOW holds until start or Reset. start in SHOW restarts at READ and wins over a same-cycle buttonNext.
// - start while busy is ignored; buttonNext outside SHOW is ignored.
// - If all scores are 8191, best=8191 with bestIdx=1 (no strict improvement over the seed).
// - All outputs are registered, except DisplayScore in the individual-score views: there it is the
//   combinational register-file read, valid in the same cycle as regAddrP.
// STRUCTURE
// - Shared package: state encodings (IDLE/READ/DIVIDE/SHOW), viewSel codes (VIEW_AVG=0, VIEW_BEST=1,
//   VIEW_SCORE=2), the 13-bit score width constant, and SCORE_MAX=13'h1FFF.
// - One sub-module: serial_divider, a restoring divider of width SUM_W with a constant divisor:
//   - inputs: load pulse, dividend;
//   - outputs: quotient, done after SUM_W cycles.
// - The FSM, accumulator, min tracker and view counter stay in score_readout.
// TESTING
// - Reg file {1:100, 2:200, 3:300}, pulse start -> busy for 18 cycles; SHOW view0=200; Next -> view1=100, scoreIndex=1.
// - {1:10, 2:11, 3:11} -> avg=10 (32/3 floored); best=10, bestIdx=1; Next x4 -> DisplayScore 10, 10, 11, 11, then wraps to avg=10.
// - {1:8191, 2:8191, 3:8191} -> avg=8191 with no overflow; best=8191, bestIdx=1.
// - {1:50, 2:40, 3:40} -> best=40, bestIdx=2 (tie keeps the lower index); avg=43.
// - Reset asserted on cycle 5 of DIVIDE -> next cycle IDLE, all outputs 0.
//   A following start then completes normally with correct results.
// - start pulsed again during READ -> ignored, results unchanged.
//   start together with buttonNext in SHOW -> restart (busy=1), view not advanced.

Source files
------------

// File: rtl/score_readout_pkg.sv
// Shared definitions for the score readout block: FSM states, view codes and score limits.
package score_readout_pkg;

    localparam int unsigned SCORE_W = 13;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 13'h1FFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_SHOW   = 2'd3
    } state_t;

    localparam logic [1:0] VIEW_AVG   = 2'd0;
    localparam logic [1:0] VIEW_BEST  = 2'd1;
    localparam logic [1:0] VIEW_SCORE = 2'd2;

endpackage

// File: rtl/serial_divider.sv
// Restoring shift-subtract divider by a constant divisor, one quotient bit per cycle.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_load          one-cycle pulse: capture i_dividend and perform the first step
//   i_dividend      value to divide
//   o_quotient      quotient register (final once o_done is high, held until next load)
//   o_done          high once all WIDTH steps have completed, cleared by i_load
module serial_divider #(
    parameter int unsigned WIDTH   = 15,
    parameter int unsigned DIVISOR = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_dividend,
    output logic [WIDTH-1:0] o_quotient,
    output logic             o_done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0] W_DIVISOR = (WIDTH + 1)'(DIVISOR);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    logic [WIDTH-1:0] w_rem_src;
    logic [WIDTH-1:0] w_quo_src;
    logic [WIDTH:0]   w_shift;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    // One restoring step; on load the step starts from a fresh dividend so the
    // load cycle already produces the first quotient bit.
    always_comb begin
        w_rem_src  = i_load ? '0 : r_rem;
        w_quo_src  = i_load ? i_dividend : r_quo;
        w_shift    = {w_rem_src, w_quo_src[WIDTH-1]};
        w_fits     = (w_shift >= W_DIVISOR);
        w_rem_next = w_fits ? WIDTH'(w_shift - W_DIVISOR) : WIDTH'(w_shift);
        w_quo_next = {w_quo_src[WIDTH-2:0], w_fits};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_load) begin
            r_rem  <= w_rem_next;
            r_quo  <= w_quo_next;
            r_cnt  <= CNT_W'(WIDTH - 1);
            r_done <= (WIDTH == 1);
        end else if (r_cnt != '0) begin
            r_rem  <= w_rem_next;
            r_quo  <= w_quo_next;
            r_cnt  <= r_cnt - CNT_W'(1);
            r_done <= (r_cnt == CNT_W'(1));
        end
    end

    assign o_quotient = r_quo;
    assign o_done     = r_done;

endmodule

// File: rtl/score_readout.sv
// Post-game score readout: reads the stored reaction times, computes average and best,
// then pages through average / best / individual scores on the display.
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_start              game-over pulse, starts a readout (ignored while busy)
//   i_button_next        advance display view (SHOW only)
//   o_reg_addr_p         register file read address, port P
//   i_register_data_p    register file read data (combinational)
//   o_display_score      displayed value
//   o_view_sel           0=average, 1=best, 2=individual score
//   o_score_index        address of the displayed score (best/individual), else 0
//   o_busy               high while reading and dividing
//   o_done               high while showing results
module score_readout
    import score_readout_pkg::*;
#(
    parameter int unsigned NUM_SCORES = 3,
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned SUM_W      = 15
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_button_next,
    output logic [ADDR_W-1:0]  o_reg_addr_p,
    input  logic [SCORE_W-1:0] i_register_data_p,
    output logic [SCORE_W-1:0] o_display_score,
    output logic [1:0]         o_view_sel,
    output logic [ADDR_W-1:0]  o_score_index,
    output logic               o_busy,
    output logic               o_done
);

    localparam int unsigned VIEW_W = $clog2(NUM_SCORES + 2);
    localparam logic [VIEW_W-1:0] VIEW_LAST = VIEW_W'(NUM_SCORES + 1);

    state_t               r_state, w_state_next;
    logic [ADDR_W-1:0]    r_addr, w_addr_next;
    logic [SUM_W-1:0]     r_sum, w_sum_next;
    logic [SCORE_W-1:0]   r_best, w_best_next;
    logic [ADDR_W-1:0]    r_best_idx, w_best_idx_next;
    logic [VIEW_W-1:0]    r_view, w_view_next;
    logic [SCORE_W-1:0]   r_disp, w_disp_next;
    logic [1:0]           r_view_sel, w_view_sel_next;
    logic [ADDR_W-1:0]    r_score_index, w_score_index_next;
    logic                 r_busy, w_busy_next;
    logic                 r_done, w_done_next;

    logic [SUM_W-1:0]     w_sum_acc;
    logic [VIEW_W-1:0]    w_view_inc;
    logic                 w_restart;
    logic                 w_div_load;
    logic [SUM_W-1:0]     w_quotient;
    logic                 w_div_done;

    serial_divider #(
        .WIDTH   (SUM_W),
        .DIVISOR (NUM_SCORES)
    ) u_div (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_div_load),
        .i_dividend (w_sum_acc),
        .o_quotient (w_quotient),
        .o_done     (w_div_done)
    );

    assign w_sum_acc = r_sum + SUM_W'(i_register_data_p);

    // Next-state and next-output logic.
    always_comb begin
        w_state_next       = r_state;
        w_addr_next        = r_addr;
        w_sum_next         = r_sum;
        w_best_next        = r_best;
        w_best_idx_next    = r_best_idx;
        w_view_next        = r_view;
        w_disp_next        = r_disp;
        w_view_sel_next    = r_view_sel;
        w_score_index_next = r_score_index;
        w_busy_next        = r_busy;
        w_done_next        = r_done;
        w_div_load         = 1'b0;
        w_view_inc         = (r_view == VIEW_LAST) ? '0 : r_view + VIEW_W'(1);
        w_restart          = i_start && ((r_state == ST_IDLE) || (r_state == ST_SHOW));

        case (r_state)
            ST_IDLE: begin
            end
            ST_READ: begin
                w_sum_next = w_sum_acc;
                // Strict compare: ties keep the earlier (lower) index.
                if (i_register_data_p < r_best) begin
                    w_best_next     = i_register_data_p;
                    w_best_idx_next = r_addr;
                end
                if (r_addr == ADDR_W'(NUM_SCORES)) begin
                    w_div_load   = 1'b1;
                    w_state_next = ST_DIVIDE;
                    w_addr_next  = '0;
                end else begin
                    w_addr_next = r_addr + ADDR_W'(1);
                end
            end
            ST_DIVIDE: begin
                if (w_div_done) begin
                    w_state_next       = ST_SHOW;
                    w_busy_next        = 1'b0;
                    w_done_next        = 1'b1;
                    w_view_next        = '0;
                    w_disp_next        = SCORE_W'(w_quotient);
                    w_view_sel_next    = VIEW_AVG;
                    w_score_index_next = '0;
                end
            end
            ST_SHOW: begin
                if (i_button_next) begin
                    w_view_next = w_view_inc;
                    if (w_view_inc == '0) begin
                        w_disp_next        = SCORE_W'(w_quotient);
                        w_view_sel_next    = VIEW_AVG;
                        w_score_index_next = '0;
                        w_addr_next        = '0;
                    end else if (w_view_inc == VIEW_W'(1)) begin
                        w_disp_next        = r_best;
                        w_view_sel_next    = VIEW_BEST;
                        w_score_index_next = r_best_idx;
                        w_addr_next        = '0;
                    end else begin
                        // Individual view: display comes straight from the read port.
                        w_disp_next        = '0;
                        w_view_sel_next    = VIEW_SCORE;
                        w_score_index_next = ADDR_W'(w_view_inc - VIEW_W'(1));
                        w_addr_next        = ADDR_W'(w_view_inc - VIEW_W'(1));
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Start (from IDLE or SHOW) wins over a same-cycle buttonNext.
        if (w_restart) begin
            w_state_next       = ST_READ;
            w_addr_next        = ADDR_W'(1);
            w_sum_next         = '0;
            w_best_next        = SCORE_MAX;
            w_best_idx_next    = ADDR_W'(1);
            w_view_next        = '0;
            w_disp_next        = '0;
            w_view_sel_next    = VIEW_AVG;
            w_score_index_next = '0;
            w_busy_next        = 1'b1;
            w_done_next        = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr        <= '0;
            r_sum         <= '0;
            r_best        <= '0;
            r_best_idx    <= '0;
            r_view        <= '0;
            r_disp        <= '0;
            r_view_sel    <= VIEW_AVG;
            r_score_index <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_addr        <= w_addr_next;
            r_sum         <= w_sum_next;
            r_best        <= w_best_next;
            r_best_idx    <= w_best_idx_next;
            r_view        <= w_view_next;
            r_disp        <= w_disp_next;
            r_view_sel    <= w_view_sel_next;
            r_score_index <= w_score_index_next;
            r_busy        <= w_busy_next;
            r_done        <= w_done_next;
        end
    end

    assign o_reg_addr_p    = r_addr;
    assign o_display_score = (r_view_sel == VIEW_SCORE) ? i_register_data_p : r_disp;
    assign o_view_sel      = r_view_sel;
    assign o_score_index   = r_score_index;
    assign o_busy          = r_busy;
    assign o_done          = r_done;

endmodule

// File: tb/tb_score_readout.sv
// Bench for score_readout: register-file model, timeline-based reference model,
// per-cycle compare on the falling edge, directed cases plus randomized games.
module tb_score_readout;
    import score_readout_pkg::*;

    localparam int unsigned N      = 3;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned SUM_W  = 15;
    localparam int          LAT    = N + SUM_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              button_next;
    logic [ADDR_W-1:0] reg_addr_p;
    logic [12:0]       register_data_p;
    logic [12:0]       display_score;
    logic [1:0]        view_sel;
    logic [ADDR_W-1:0] score_index;
    logic              busy;
    logic              done;

    logic [12:0] rf [0:7];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign register_data_p = rf[reg_addr_p];

    score_readout #(
        .NUM_SCORES (N),
        .ADDR_W     (ADDR_W),
        .SUM_W      (SUM_W)
    ) dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_start           (start),
        .i_button_next     (button_next),
        .o_reg_addr_p      (reg_addr_p),
        .i_register_data_p (register_data_p),
        .o_display_score   (display_score),
        .o_view_sel        (view_sel),
        .o_score_index     (score_index),
        .o_busy            (busy),
        .o_done            (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: phase 0=idle, 1=busy (m_k edges since start), 2=show.
    int m_phase = 0;
    int m_k     = 0;
    int m_view  = 0;
    int m_avg   = 0;
    int m_best  = 0;
    int m_bidx  = 0;
    bit m_valid = 1'b0;

    task automatic model_compute();
        int s;
        s      = 0;
        m_best = 8191;
        m_bidx = 1;
        for (int i = 1; i <= N; i++) begin
            s += int'(rf[i]);
            if (int'(rf[i]) < m_best) begin
                m_best = int'(rf[i]);
                m_bidx = i;
            end
        end
        m_avg = s / N;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_view  = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1; m_k = 0; model_compute();
                end
                1: if (m_k == LAT - 1) begin
                    m_phase = 2; m_view = 0;
                end else begin
                    m_k++;
                end
                default: if (start) begin
                    m_phase = 1; m_k = 0; model_compute();
                end else if (button_next) begin
                    m_view = (m_view + 1) % (N + 2);
                end
            endcase
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        int e_addr, e_disp, e_sel, e_idx, e_busy, e_done;
        if (m_valid) begin
            e_addr = 0; e_disp = 0; e_sel = 0; e_idx = 0; e_busy = 0; e_done = 0;
            if (m_phase == 1) begin
                e_busy = 1;
                e_addr = (m_k < N) ? m_k + 1 : 0;
            end else if (m_phase == 2) begin
                e_done = 1;
                if (m_view == 0) begin
                    e_disp = m_avg;
                end else if (m_view == 1) begin
                    e_disp = m_best; e_sel = 1; e_idx = m_bidx;
                end else begin
                    e_addr = m_view - 1; e_idx = m_view - 1; e_sel = 2;
                    e_disp = int'(rf[m_view - 1]);
                end
            end
            chk("addr", 32'(reg_addr_p), 32'(e_addr));
            chk("display", 32'(display_score), 32'(e_disp));
            chk("view_sel", 32'(view_sel), 32'(e_sel));
            chk("score_index", 32'(score_index), 32'(e_idx));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_next();
        button_next = 1'b1; tick(); button_next = 1'b0;
    endtask

    task automatic load(input int a, input int b, input int c);
        rf[1] = 13'(a); rf[2] = 13'(b); rf[3] = 13'(c);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && !done; i++) tick();
        chk("wait_done", 32'(done), 32'd1);
    endtask

    initial begin
        int nb;
        int exp_seq [5];
        for (int i = 0; i < 8; i++) rf[i] = '0;
        rf[0] = 13'd7;
        reset = 1'b1; start = 1'b0; button_next = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_disp", 32'(display_score), 32'd0);
        reset = 1'b0;
        tick();

        // Basic: busy length, average and best.
        load(100, 200, 300);
        pulse_start();
        nb = 0;
        for (int i = 0; i < 40 && busy; i++) begin nb++; tick(); end
        chk("busy_cycles", 32'(nb), 32'd18);
        chk("t1_avg", 32'(display_score), 32'd200);
        pulse_next();
        chk("t1_best", 32'(display_score), 32'd100);
        chk("t1_best_idx", 32'(score_index), 32'd1);

        // Floor division and full wrap of the views.
        load(10, 11, 11);
        pulse_start(); wait_done();
        chk("t2_avg", 32'(display_score), 32'd10);
        exp_seq = '{10, 10, 11, 11, 10};
        for (int i = 0; i < 5; i++) begin
            pulse_next();
            chk("t2_view", 32'(display_score), 32'(exp_seq[i]));
        end

        // All maximum values.
        load(8191, 8191, 8191);
        pulse_start(); wait_done();
        chk("t3_avg", 32'(display_score), 32'd8191);
        pulse_next();
        chk("t3_best", 32'(display_score), 32'd8191);
        chk("t3_best_idx", 32'(score_index), 32'd1);

        // Tie keeps lower index.
        load(50, 40, 40);
        pulse_start(); wait_done();
        chk("t4_avg", 32'(display_score), 32'd43);
        pulse_next();
        chk("t4_best", 32'(display_score), 32'd40);
        chk("t4_best_idx", 32'(score_index), 32'd2);

        // Reset in the middle of the divide.
        load(100, 200, 300);
        pulse_start();
        repeat (7) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_addr", 32'(reg_addr_p), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        pulse_start(); wait_done();
        chk("t5_avg", 32'(display_score), 32'd200);

        // Start during READ ignored.
        load(1000, 2000, 3000);
        pulse_start();
        pulse_start();
        wait_done();
        chk("t6_avg", 32'(display_score), 32'd2000);

        // Start with buttonNext in SHOW restarts.
        pulse_next();
        start = 1'b1; button_next = 1'b1; tick(); start = 1'b0; button_next = 1'b0;
        chk("t7_busy", 32'(busy), 32'd1);
        chk("t7_sel", 32'(view_sel), 32'd0);
        wait_done();
        chk("t7_avg", 32'(display_score), 32'd2000);

        // Randomized games.
        for (int it = 0; it < 40; it++) begin
            int mode;
            mode = int'($urandom_range(0, 3));
            for (int i = 1; i <= N; i++) begin
                case (mode)
                    0: rf[i] = 13'($urandom_range(0, 8191));
                    1: rf[i] = 13'($urandom_range(0, 3));
                    2: rf[i] = ($urandom_range(0, 1) == 0) ? 13'h1FFF : 13'($urandom_range(8180, 8191));
                    default: rf[i] = 13'($urandom_range(0, 200));
                endcase
            end
            pulse_start();
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 20)) tick();
                reset = 1'b1; tick(); reset = 1'b0;
                continue;
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 10)) tick();
                pulse_start();
            end
            wait_done();
            repeat ($urandom_range(0, 8)) begin
                button_next = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 15) == 0) start = 1'b1;
                tick();
                button_next = 1'b0;
                start = 1'b0;
                if (!done) wait_done();
                if ($urandom_range(0, 3) == 0) rf[$urandom_range(1, N)] = 13'($urandom_range(0, 8191));
            end
        end
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
